// File: rtl/sdr_host_pkg.sv
// sdr_host_pkg: shared types and constants for the SDRAM host command front end.
package sdr_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    WR_REQ,
    WR_DATA,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    FIN
  } state_t;

  // Word address layout seen by the controller
  localparam int BANK_MSB  = 24;
  localparam int BANK_LSB  = 23;
  localparam int ROW_MSB   = 22;
  localparam int ROW_LSB   = 10;
  localparam int COL_MSB   = 9;
  localparam int COL_LSB   = 0;
  localparam int ROW_WORDS = 1024;

endpackage

// File: rtl/sdr_host_if_if.sv
// sdr_host_if_if: host command/data port and SDRAM controller request port of the front end.
// The front end uses the slave view; the host plus controller environment uses the master view.
interface sdr_host_if_if #(parameter int LEN_W = 12);
  logic             host_cmd_vld;
  logic             host_cmd_rdy;
  logic             host_cmd_wr;
  logic [31:0]      host_cmd_addr;
  logic [LEN_W-1:0] host_cmd_len;
  logic [15:0]      host_wdata;
  logic             host_wvld;
  logic             host_wrdy;
  logic [15:0]      host_rdata;
  logic             host_rvld;
  logic             host_done;

  logic             sdr_wr_req;
  logic [31:0]      sdr_waddr;
  logic [11:0]      sdr_wr_byte_cnt;
  logic [15:0]      sdr_wdata_in;
  logic             sdr_wdata_wr;
  logic             sdr_wr_ready;
  logic             sdr_wr_done;
  logic             sdr_rd_req;
  logic [31:0]      sdr_raddr;
  logic [11:0]      sdr_rd_word_cnt;
  logic [15:0]      sdr_rdata_out;
  logic             sdr_rd_vld;
  logic             sdr_rd_done;

  modport master (
    output host_cmd_vld, host_cmd_wr, host_cmd_addr, host_cmd_len, host_wdata, host_wvld,
    output sdr_wr_ready, sdr_wr_done, sdr_rdata_out, sdr_rd_vld, sdr_rd_done,
    input  host_cmd_rdy, host_wrdy, host_rdata, host_rvld, host_done,
    input  sdr_wr_req, sdr_waddr, sdr_wr_byte_cnt, sdr_wdata_in, sdr_wdata_wr,
    input  sdr_rd_req, sdr_raddr, sdr_rd_word_cnt
  );

  modport slave (
    input  host_cmd_vld, host_cmd_wr, host_cmd_addr, host_cmd_len, host_wdata, host_wvld,
    input  sdr_wr_ready, sdr_wr_done, sdr_rdata_out, sdr_rd_vld, sdr_rd_done,
    output host_cmd_rdy, host_wrdy, host_rdata, host_rvld, host_done,
    output sdr_wr_req, sdr_waddr, sdr_wr_byte_cnt, sdr_wdata_in, sdr_wdata_wr,
    output sdr_rd_req, sdr_raddr, sdr_rd_word_cnt
  );
endinterface

// File: rtl/sdr_chunk_calc.sv
// sdr_chunk_calc: combinational chunk length, min(remaining, CHUNK_MAX, words left in row).
// The row term is active only when SDR_HOST_ROWSPLIT_EN is defined.
module sdr_chunk_calc
  import sdr_host_pkg::*;
#(
  parameter int CHUNK_MAX = 256,
  parameter int LEN_W     = 12
) (
  input  logic [LEN_W-1:0] remaining,
  input  logic [9:0]       col,
  output logic [11:0]      chunk
);

`ifdef SDR_HOST_ROWSPLIT_EN
  localparam bit ROW_LIMIT = 1'b1;
`else
  localparam bit ROW_LIMIT = 1'b0;
`endif

  logic [10:0] row_left;

  always_comb begin
    row_left = 11'(ROW_WORDS) - {1'b0, col};
    chunk    = 12'(CHUNK_MAX);
    if (32'(remaining) < 32'(CHUNK_MAX))
      chunk = 12'(remaining);
    if (ROW_LIMIT && ({1'b0, row_left} < chunk))
      chunk = {1'b0, row_left};
  end

endmodule

// File: rtl/sdr_host_if.sv
// sdr_host_if: splits host read/write commands into controller-sized chunks, streams
// write data into the controller FIFO and forwards read beats back to the host.
module sdr_host_if
  import sdr_host_pkg::*;
#(
  parameter int CHUNK_MAX = 256,
  parameter int LEN_W     = 12
) (
  input logic          clk,
  input logic          rst_n,
  sdr_host_if_if.slave bus
);

  state_t           state, state_nxt;
  logic             out_en;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] remaining;
  logic             is_wr;
  logic [11:0]      beats_left;
  logic [11:0]      chunk;
  logic [31:0]      waddr_q, raddr_q;
  logic [11:0]      wcnt_q, rcnt_q;
  logic [15:0]      rdata_q;
  logic             rvld_q;
  logic             wrdy;
  logic             push;
  logic             accept;

  sdr_chunk_calc #(.CHUNK_MAX(CHUNK_MAX), .LEN_W(LEN_W)) u_chunk (
    .remaining(remaining),
    .col      (addr_q[COL_MSB:COL_LSB]),
    .chunk    (chunk)
  );

  // out_en keeps host_cmd_rdy low while reset is held, rising on the first clock after release
  assign accept = bus.host_cmd_vld & out_en & (state == IDLE);
  assign wrdy   = (state == WR_DATA) & bus.sdr_wr_ready & (beats_left != 12'd0);
  assign push   = bus.host_wvld & wrdy;

  assign bus.host_cmd_rdy    = out_en & (state == IDLE);
  assign bus.host_wrdy       = wrdy;
  assign bus.host_rdata      = rdata_q;
  assign bus.host_rvld       = rvld_q;
  assign bus.host_done       = (state == FIN);
  assign bus.sdr_wr_req      = (state == WR_REQ);
  assign bus.sdr_waddr       = waddr_q;
  assign bus.sdr_wr_byte_cnt = wcnt_q;
  assign bus.sdr_wdata_in    = (state == WR_DATA) ? bus.host_wdata : 16'd0;
  assign bus.sdr_wdata_wr    = push;
  assign bus.sdr_rd_req      = (state == RD_REQ);
  assign bus.sdr_raddr       = raddr_q;
  assign bus.sdr_rd_word_cnt = rcnt_q;

  // Chunk bookkeeping advances in CALC, so the chunk registers still hold the old address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_en     <= 1'b0;
      addr_q     <= '0;
      remaining  <= '0;
      is_wr      <= 1'b0;
      beats_left <= '0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      rdata_q    <= '0;
      rvld_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      out_en <= 1'b1;
      rvld_q <= (state == RD_WAIT) & bus.sdr_rd_vld;
      if ((state == RD_WAIT) && bus.sdr_rd_vld)
        rdata_q <= bus.sdr_rdata_out;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= bus.host_cmd_addr;
            remaining <= bus.host_cmd_len;
            is_wr     <= bus.host_cmd_wr;
          end
        end
        CALC: begin
          addr_q     <= addr_q + 32'(chunk);
          remaining  <= remaining - LEN_W'(chunk);
          beats_left <= chunk;
          if (is_wr) begin
            waddr_q <= addr_q;
            wcnt_q  <= {chunk[10:0], 1'b0};
          end else begin
            raddr_q <= addr_q;
            rcnt_q  <= chunk;
          end
        end
        WR_DATA: begin
          if (push)
            beats_left <= beats_left - 12'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept)
          state_nxt = (bus.host_cmd_len == '0) ? FIN : CALC;
      end
      CALC:    state_nxt = is_wr ? WR_REQ : RD_REQ;
      WR_REQ:  state_nxt = WR_DATA;
      WR_DATA: begin
        if (push && (beats_left == 12'd1))
          state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        if (bus.sdr_wr_done)
          state_nxt = (remaining == '0) ? FIN : CALC;
      end
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (bus.sdr_rd_done)
          state_nxt = (remaining == '0) ? FIN : CALC;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
